// File: rtl/dcnt_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcnt_timer_ctrl
// Purpose  : Countdown timer controller for the 4-bit down-counter datapath.
//            Generates a prescaled decrement tick and sequences load, start,
//            pause, abort and expiry. The count saturates at zero, emits a
//            one-cycle done pulse and raises a sticky interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module dcnt_timer_ctrl #(
   parameter int WIDTH   = 4,
   parameter int PRESC_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   load_val,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               start,
   input  logic               stop,
   input  logic               auto_reload,
   input  logic               irq_ack,
   output logic [WIDTH-1:0]   count,
   output logic               tick,
   output logic               busy,
   output logic               done,
   output logic               irq
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PAUSED  = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0]   C_CNT_ONE   = WIDTH'(1);
   localparam logic [PRESC_W-1:0] C_PRESC_ONE = PRESC_W'(1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_count;
   logic [WIDTH-1:0]     w_count_nxt;
   logic [WIDTH-1:0]     r_reload;
   logic [WIDTH-1:0]     w_reload_nxt;
   logic [PRESC_W-1:0]   r_presc;
   logic [PRESC_W-1:0]   w_presc_nxt;
   logic                 r_tick;
   logic                 w_tick_nxt;
   logic                 r_irq;
   logic                 w_irq_nxt;
   logic                 w_tick_due;

   // Prescaler compare against the live prescale value; a value already
   // passed by the counter only matches again after the counter wraps.
   assign w_tick_due = (r_presc == prescale);

   // Next-state and datapath decode; stop has priority over start everywhere.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_presc_nxt  = r_presc;
      w_tick_nxt   = 1'b0;
      w_irq_nxt    = irq_ack ? 1'b0 : r_irq;

      case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_reload_nxt = load_val;
               w_count_nxt  = load_val;
               w_presc_nxt  = '0;
               w_state_nxt  = (load_val == '0) ? S_EXPIRED : S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               // Pause freezes everything, even a tick that was due now.
               w_state_nxt = S_PAUSED;
            end else if (w_tick_due) begin
               w_presc_nxt = '0;
               // Count saturates at zero; the guard only matters if RUN is
               // ever entered with a zero count.
               if (r_count != '0) begin
                  w_count_nxt = r_count - C_CNT_ONE;
                  w_tick_nxt  = 1'b1;
                  if (r_count == C_CNT_ONE) begin
                     w_state_nxt = S_EXPIRED;
                  end
               end else begin
                  w_state_nxt = S_EXPIRED;
               end
            end else begin
               w_presc_nxt = r_presc + C_PRESC_ONE;
            end
         end
         S_PAUSED: begin
            if (stop) begin
               // Abort: back to idle without a done pulse.
               w_state_nxt = S_IDLE;
               w_count_nxt = '0;
               w_presc_nxt = '0;
            end else if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_EXPIRED: begin
            if (auto_reload && (r_reload != '0)) begin
               w_count_nxt = r_reload;
               w_presc_nxt = '0;
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Entering expiry sets the interrupt; this overrides an ack.
      if ((w_state_nxt == S_EXPIRED) && (r_state != S_EXPIRED)) begin
         w_irq_nxt = 1'b1;
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_presc  <= '0;
         r_tick   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_reload <= w_reload_nxt;
         r_presc  <= w_presc_nxt;
         r_tick   <= w_tick_nxt;
         r_irq    <= w_irq_nxt;
      end
   end

   assign count = r_count;
   assign tick  = r_tick;
   assign irq   = r_irq;
   assign busy  = (r_state != S_IDLE);
   assign done  = (r_state == S_EXPIRED);

endmodule
`default_nettype wire

// File: tb/tb_dcnt_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcnt_timer_ctrl
// Purpose  : Self-checking bench for dcnt_timer_ctrl. A behavioural timer
//            model tracks mode, remaining count and cycles-since-tick; a
//            negedge compare process checks every output each cycle, and
//            directed sequences pin the model with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcnt_timer_ctrl;

   localparam int WIDTH   = 4;
   localparam int PRESC_W = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic [WIDTH-1:0]   load_val;
   logic [PRESC_W-1:0] prescale;
   logic               start;
   logic               stop;
   logic               auto_reload;
   logic               irq_ack;
   logic [WIDTH-1:0]   count;
   logic               tick;
   logic               busy;
   logic               done;
   logic               irq;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Model: mode 0=idle 1=counting 2=paused 3=expired
   int                 m_mode;
   logic [WIDTH-1:0]   m_count;
   logic [WIDTH-1:0]   m_reload;
   logic [PRESC_W-1:0] m_phase;
   bit                 m_tick;
   bit                 m_irq;

   dcnt_timer_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_val    (load_val),
      .prescale    (prescale),
      .start       (start),
      .stop        (stop),
      .auto_reload (auto_reload),
      .irq_ack     (irq_ack),
      .count       (count),
      .tick        (tick),
      .busy        (busy),
      .done        (done),
      .irq         (irq)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode   = 0;
      m_count  = '0;
      m_reload = '0;
      m_phase  = '0;
      m_tick   = 1'b0;
      m_irq    = 1'b0;
   endtask

   // One clock edge of timer behaviour, from the rules for each mode.
   task automatic model_edge();
      bit new_tick;
      bit expire;
      new_tick = 1'b0;
      expire   = 1'b0;
      if (m_mode == 0) begin
         if (start && !stop) begin
            m_reload = load_val;
            m_count  = load_val;
            m_phase  = '0;
            if (load_val == 0) begin m_mode = 3; expire = 1'b1; end
            else m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (stop) m_mode = 2;
         else if (m_phase == prescale) begin
            m_phase  = '0;
            m_count  = m_count - 1'b1;
            new_tick = 1'b1;
            if (m_count == 0) begin m_mode = 3; expire = 1'b1; end
         end else m_phase = m_phase + 1'b1;
      end else if (m_mode == 2) begin
         if (stop) begin m_mode = 0; m_count = '0; m_phase = '0; end
         else if (start) m_mode = 1;
      end else begin
         if (auto_reload && m_reload != 0) begin
            m_count = m_reload; m_phase = '0; m_mode = 1;
         end else m_mode = 0;
      end
      m_tick = new_tick;
      if (expire) m_irq = 1'b1;
      else if (irq_ack) m_irq = 1'b0;
   endtask

   // Advance one edge, update model, leave time at edge+1.
   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      #1;
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         check("count", int'(count), int'(m_count));
         check("tick",  int'(tick),  int'(m_tick));
         check("busy",  int'(busy),  int'(m_mode != 0));
         check("done",  int'(done),  int'(m_mode == 3));
         check("irq",   int'(irq),   int'(m_irq));
      end
   end

   initial begin
      int dones;
      reset = 1'b1; load_val = '0; prescale = '0; start = 1'b0; stop = 1'b0;
      auto_reload = 1'b0; irq_ack = 1'b0;
      model_reset();
      step(); step();
      check("rst_count", int'(count), 0);
      check("rst_busy",  int'(busy),  0);
      check("rst_irq",   int'(irq),   0);
      check("rst_done",  int'(done),  0);
      reset = 1'b0;
      chk_en = 1'b1;
      step();

      // 1: load 4, prescale 0, one-shot
      load_val = 4'd4; prescale = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      check("t1_count0", int'(count), 4);
      for (int k = 1; k <= 4; k++) begin
         step();
         check("t1_count", int'(count), 4 - k);
      end
      check("t1_done", int'(done), 1);
      check("t1_irq",  int'(irq),  1);
      step();
      check("t1_done_off", int'(done), 0);
      check("t1_busy_off", int'(busy), 0);

      // 2: load 3, prescale 2, auto-reload, period 10
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      check("t2_ack", int'(irq), 0);
      load_val = 4'd3; prescale = 8'd2; auto_reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      dones = 0;
      for (int k = 1; k <= 30; k++) begin
         if (k == 30) auto_reload = 1'b0;
         irq_ack = (k == 12);
         step();
         if (done) dones++;
         if (k == 3)  check("t2_first_dec", int'(count), 2);
         if (k == 9 || k == 19 || k == 29) check("t2_done_at", int'(done), 1);
         if (k == 10) check("t2_reload", int'(count), 3);
         if (k == 12) check("t2_irq_clr", int'(irq), 0);
         if (k == 19) check("t2_irq_set", int'(irq), 1);
      end
      irq_ack = 1'b0;
      check("t2_dones", dones, 3);
      check("t2_idle", int'(busy), 0);

      // 3: load 5, prescale 1, pause at count 3, resume
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
      load_val = 4'd5; prescale = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step(); step();
      check("t3_pre_pause", int'(count), 3);
      stop = 1'b1; step(); stop = 1'b0;
      for (int k = 0; k < 6; k++) step();
      check("t3_hold", int'(count), 3);
      check("t3_busy", int'(busy), 1);
      start = 1'b1; step(); start = 1'b0;
      for (int k = 0; k < 6; k++) step();
      check("t3_done", int'(done), 1);
      step();

      // 4: start+stop together in PAUSED aborts
      load_val = 4'd5; prescale = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      stop = 1'b1; step();
      start = 1'b1; step();
      start = 1'b0; stop = 1'b0;
      check("t4_count", int'(count), 0);
      check("t4_busy",  int'(busy),  0);
      check("t4_done",  int'(done),  0);
      check("t4_irq",   int'(irq),   1);
      step(); step();

      // 5: load 0 expires immediately, no reload
      load_val = 4'd0; auto_reload = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      check("t5_done", int'(done), 1);
      step();
      check("t5_idle", int'(busy), 0);
      auto_reload = 1'b0;

      // 6: prescale lowered below the running prescaler count
      load_val = 4'd3; prescale = 8'd5; start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      prescale = 8'd1;
      for (int k = 3; k <= 270; k++) begin
         step();
         if (k == 257) check("t6_wrap_hold", int'(count), 3);
         if (k == 258) check("t6_wrap_dec", int'(count), 2);
      end
      check("t6_idle", int'(busy), 0);

      // 7: async reset mid-count
      load_val = 4'd15; prescale = 8'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) step();
      check("t7_pre", int'(count), 7);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("t7_count", int'(count), 0);
      check("t7_busy",  int'(busy),  0);
      check("t7_irq",   int'(irq),   0);
      check("t7_done",  int'(done),  0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 20; k++) step();
      check("t7_after", int'(done), 0);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
